// File: rtl/clock_divider_prog.sv
// clock_divider_prog: programmable integer clock divider with glitch-free divisor update at period wrap
module clock_divider_prog #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 5
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk,
    output logic             clk_en,
    output logic [WIDTH-1:0] div_active,
    output logic             busy
);
    localparam logic [WIDTH-1:0] RST_DIV = (RESET_DIV < 2) ? WIDTH'(2) : WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pending;
    logic             r_clk;
    logic             r_busy;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wrap;
    logic             w_apply;

    // Counter next state, wrap/apply decisions and the pre-rise enable pulse
    always_comb begin
        w_half     = r_div >> 1;
        w_wrap     = r_cnt >= (r_div - WIDTH'(1));
        w_apply    = r_busy && (!en || w_wrap);
        w_cnt_nxt  = (!en || w_wrap) ? '0 : r_cnt + WIDTH'(1);
        w_load_val = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
        clk_en     = reset && en && (r_cnt == (w_half - WIDTH'(1)));
    end

    // Count, register the divided clock from the next count, and swap divisors only at a wrap
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_clk     <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= '0;
            r_div     <= RST_DIV;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_clk  <= w_cnt_nxt >= w_half;
            r_busy <= div_load || (r_busy && !w_apply);
            if (w_apply)
                r_div <= r_pending;
            if (div_load)
                r_pending <= w_load_val;
        end
    end

    assign clk        = r_clk;
    assign div_active = r_div;
    assign busy       = r_busy;
endmodule

// File: doc/clock_divider_prog.md
CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 Parameter WIDTH, default 8: width of divisor and counter.
REQ-002 Parameter RESET_DIV, default 5: divisor active out of reset, clamped per REQ-012.
REQ-003 clk50  input  1  sole clock; every flop is posedge clk50.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it forces every flop to its reset value immediately.
REQ-005 en  input  1  divider run enable, sampled on posedge clk50.
REQ-006 div_in  input  WIDTH  requested divide ratio N.
REQ-007 div_load  input  1  single-cycle strobe; captures div_in as the pending divisor.
REQ-008 clk  output  1  divided clock, driven directly from a flop.
REQ-009 clk_en  output  1  one-clk50-cycle pulse, high in the cycle before each clk rising edge.
REQ-010 div_active  output  WIDTH  divisor currently in effect, after clamping.
REQ-011 busy  output  1  high while a loaded divisor is pending and not yet applied.

Function
REQ-012 Clamp: any captured value below 2 (0 or 1) SHALL become 2; the legal range is 2..2^WIDTH-1.
REQ-013 Counter cnt (WIDTH bits) SHALL increment each cycle while en=1 and wrap from N-1 to 0, giving an N-cycle period.
REQ-014 Low-phase length L = floor(N/2); clk SHALL equal (cnt >= L), registered so it is glitch-free.
REQ-015 Phase lengths: clk low for L cycles, high for N-L cycles; even N gives exactly 50% duty, odd N is high one cycle longer.
REQ-016 clk_en SHALL be 1 exactly when en=1 and cnt == L-1, so it precedes each clk rise by one clk50 edge.
REQ-017 Capture: div_load=1 at an edge SHALL store clamp(div_in) in the pending register and set busy=1 on the next cycle.
REQ-018 Overwrite: a load while busy=1 SHALL overwrite the pending value; the last load wins and only one update is applied.
REQ-019 Apply: at an edge where busy=1 and cnt == N-1 (wrap), div_active SHALL take the pending value, cnt SHALL go to 0 and busy SHALL clear.
REQ-020 The new period starts low at cnt=0; no partial or short clk pulse SHALL occur.
REQ-021 A load coinciding with the wrap edge SHALL NOT apply at that edge; it applies at the following wrap.
REQ-022 A load coinciding with an apply edge SHALL set busy again with the new pending value.
REQ-023 Disabled: while en=0, cnt SHALL hold 0, clk SHALL be 0 and clk_en SHALL be 0.
REQ-024 Disabled loads: div_load SHALL still be accepted while en=0, and a pending divisor SHALL apply at the next edge while en=0.
REQ-025 Enable: after en rises, the first clk rise SHALL occur exactly L edges later.
REQ-026 Disable mid-period: en falling SHALL force clk low at the next edge, truncating the high phase; this is the only permitted truncation.
REQ-027 Latency: div_active SHALL update at most N_old cycles after the load edge while en=1.

Reset
REQ-028 Reset values: cnt=0, clk=0, clk_en=0, busy=0, pending=0, div_active=clamp(RESET_DIV).
REQ-029 Reset mid-period or with a load pending SHALL discard the pending divisor.
REQ-030 On reset release with en=1, counting SHALL resume from cnt=0.

Verification
REQ-031 Reset release, en=1, RESET_DIV=5 -> clk pattern 0,0,1,1,1 repeating; clk_en high on cnt=1; div_active=5.
REQ-032 Load div_in=8 mid-period at cnt=2 (N=5) -> busy=1 until wrap; then a 4-low/4-high pattern with no short pulse; busy=0.
REQ-033 Load 0 then load 1 on consecutive cycles -> div_active=2 after wrap; clk toggles every cycle; clk_en high every other cycle.
REQ-034 Load 6 on the wrap edge, then load 7 during the next period -> div_active stays 5 through one more period, then becomes 7; 6 is never applied.
REQ-035 Drop en to 0 during the high phase -> clk=0 at the next edge and cnt=0; raise en -> first rise after L cycles.
REQ-036 Assert reset with busy=1 mid-high-phase -> clk=0 and busy=0 immediately; div_active=5 after release.
